// File: rtl/reg4_8_if.sv
// Register-bank port bundle: two combinational read ports and one write port.
// The master side (datapath control) drives indices, write data and enable.
// The slave side (the register bank) returns the read data.
interface reg4_8_if #(
  parameter int WIDTH     = 8,
  parameter int ADDR_BITS = 2
);

  logic [ADDR_BITS-1:0] N1;
  logic [WIDTH-1:0]     Q1;
  logic [ADDR_BITS-1:0] N2;
  logic [WIDTH-1:0]     Q2;
  logic [ADDR_BITS-1:0] ND;
  logic [WIDTH-1:0]     DI;
  logic                 REG_WE;

  modport master (
    output N1, N2, ND, DI, REG_WE,
    input  Q1, Q2
  );

  modport slave (
    input  N1, N2, ND, DI, REG_WE,
    output Q1, Q2
  );

endinterface

// File: rtl/reg4_8.sv
// Architectural register bank: 2**ADDR_BITS entries of WIDTH bits.
// Two independent combinational read ports feed the ALU operands.
// One synchronous write port takes the writeback result.
// There is no write-to-read bypass: a read of the register being written
// returns the old value until the clock edge commits the new one.
// Every entry is writable; entry 0 is not hard-wired to zero.
module reg4_8 #(
  parameter int WIDTH     = 8,
  parameter int ADDR_BITS = 2
) (
  input  logic     Clock,
  input  logic     Reset,
  reg4_8_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];

  // Next-state of the bank: hold every entry, then overlay the single writeback.
  always_comb begin
    regs_d = regs_q;
    if (bus.REG_WE) begin
      regs_d[bus.ND] = bus.DI;
    end
  end

  // Commit on the rising edge; a synchronous reset clears the bank and wins over a write.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign bus.Q1 = regs_q[bus.N1];
  assign bus.Q2 = regs_q[bus.N2];

endmodule

// File: tb/tb_reg4_8.sv
// Directed testbench for the reg4_8 register bank.
// Each scenario task drives its own stimulus and compares the read ports
// against hand-computed values.
module tb_reg4_8;

  logic Clock;
  logic Reset;
  int   checks;
  int   errors;

  reg4_8_if #(.WIDTH(8), .ADDR_BITS(2)) bus_if ();

  reg4_8 #(.WIDTH(8), .ADDR_BITS(2)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus_if.slave)
  );

  // Free-running 10-unit clock.
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Hard stop in case the run ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // One write on the next rising edge; inputs change on the falling edge.
  task automatic do_write(input logic [1:0] nd, input logic [7:0] di);
    @(negedge Clock);
    bus_if.ND     = nd;
    bus_if.DI     = di;
    bus_if.REG_WE = 1'b1;
    @(posedge Clock);
    #1;
    bus_if.REG_WE = 1'b0;
  endtask

  task automatic test_reset;
    // Power-up reset so the bank is defined.
    @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    // Fill the bank with non-zero data.
    do_write(2'd0, 8'h12);
    do_write(2'd1, 8'h34);
    do_write(2'd2, 8'h56);
    do_write(2'd3, 8'h78);
    bus_if.N1 = 2'd2;
    bus_if.N2 = 2'd3;
    #1;
    checks++;
    if (bus_if.Q1 !== 8'h56) begin
      errors++;
      $display("[TB] FAIL prefill_r2: got %h expected %h", bus_if.Q1, 8'h56);
    end
    checks++;
    if (bus_if.Q2 !== 8'h78) begin
      errors++;
      $display("[TB] FAIL prefill_r3: got %h expected %h", bus_if.Q2, 8'h78);
    end
    // One reset edge clears everything.
    @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        bus_if.N1 = 2'(i);
        bus_if.N2 = 2'(j);
        #1;
        checks++;
        if (bus_if.Q1 !== 8'h00) begin
          errors++;
          $display("[TB] FAIL reset_q1 n1=%0d: got %h expected %h", i, bus_if.Q1, 8'h00);
        end
        checks++;
        if (bus_if.Q2 !== 8'h00) begin
          errors++;
          $display("[TB] FAIL reset_q2 n2=%0d: got %h expected %h", j, bus_if.Q2, 8'h00);
        end
      end
    end
    // Reset held high masks writes to every index.
    @(negedge Clock);
    Reset         = 1'b1;
    bus_if.REG_WE = 1'b1;
    bus_if.DI     = 8'hC3;
    for (int k = 0; k < 4; k++) begin
      bus_if.ND = 2'(k);
      @(posedge Clock);
      #1;
    end
    bus_if.REG_WE = 1'b0;
    Reset         = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_if.N1 = 2'(i);
      #1;
      checks++;
      if (bus_if.Q1 !== 8'h00) begin
        errors++;
        $display("[TB] FAIL reset_held n1=%0d: got %h expected %h", i, bus_if.Q1, 8'h00);
      end
    end
  endtask

  task automatic test_basic_write;
    do_write(2'd0, 8'h55);
    bus_if.N1 = 2'd0;
    bus_if.N2 = 2'd1;
    #1;
    checks++;
    if (bus_if.Q1 !== 8'h55) begin
      errors++;
      $display("[TB] FAIL basic_q1_r0: got %h expected %h", bus_if.Q1, 8'h55);
    end
    checks++;
    if (bus_if.Q2 !== 8'h00) begin
      errors++;
      $display("[TB] FAIL basic_q2_r1: got %h expected %h", bus_if.Q2, 8'h00);
    end
    do_write(2'd1, 8'hAA);
    #1;
    checks++;
    if (bus_if.Q1 !== 8'h55) begin
      errors++;
      $display("[TB] FAIL basic2_q1_r0: got %h expected %h", bus_if.Q1, 8'h55);
    end
    checks++;
    if (bus_if.Q2 !== 8'hAA) begin
      errors++;
      $display("[TB] FAIL basic2_q2_r1: got %h expected %h", bus_if.Q2, 8'hAA);
    end
  endtask

  task automatic test_we_gating;
    @(negedge Clock);
    bus_if.REG_WE = 1'b0;
    bus_if.ND     = 2'd2;
    bus_if.DI     = 8'hFF;
    repeat (3) @(posedge Clock);
    #1;
    bus_if.N1 = 2'd2;
    bus_if.N2 = 2'd0;
    #1;
    checks++;
    if (bus_if.Q1 !== 8'h00) begin
      errors++;
      $display("[TB] FAIL gate_r2: got %h expected %h", bus_if.Q1, 8'h00);
    end
    checks++;
    if (bus_if.Q2 !== 8'h55) begin
      errors++;
      $display("[TB] FAIL gate_r0: got %h expected %h", bus_if.Q2, 8'h55);
    end
    bus_if.N1 = 2'd1;
    bus_if.N2 = 2'd3;
    #1;
    checks++;
    if (bus_if.Q1 !== 8'hAA) begin
      errors++;
      $display("[TB] FAIL gate_r1: got %h expected %h", bus_if.Q1, 8'hAA);
    end
    checks++;
    if (bus_if.Q2 !== 8'h00) begin
      errors++;
      $display("[TB] FAIL gate_r3: got %h expected %h", bus_if.Q2, 8'h00);
    end
  endtask

  task automatic test_full_sweep;
    logic [7:0] exp_vals [4];
    exp_vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_write(2'd0, 8'h11);
    do_write(2'd1, 8'h22);
    do_write(2'd2, 8'h33);
    do_write(2'd3, 8'h44);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        bus_if.N1 = 2'(i);
        bus_if.N2 = 2'(j);
        #1;
        checks++;
        if (bus_if.Q1 !== exp_vals[i]) begin
          errors++;
          $display("[TB] FAIL sweep_q1 n1=%0d n2=%0d: got %h expected %h", i, j, bus_if.Q1, exp_vals[i]);
        end
        checks++;
        if (bus_if.Q2 !== exp_vals[j]) begin
          errors++;
          $display("[TB] FAIL sweep_q2 n1=%0d n2=%0d: got %h expected %h", i, j, bus_if.Q2, exp_vals[j]);
        end
      end
    end
  endtask

  task automatic test_write_read_timing;
    @(negedge Clock);
    bus_if.N1     = 2'd3;
    bus_if.N2     = 2'd3;
    bus_if.ND     = 2'd3;
    bus_if.DI     = 8'h5A;
    bus_if.REG_WE = 1'b1;
    #1;
    checks++;
    if (bus_if.Q1 !== 8'h44) begin
      errors++;
      $display("[TB] FAIL timing_pre_5a: got %h expected %h", bus_if.Q1, 8'h44);
    end
    @(posedge Clock);
    #1;
    checks++;
    if (bus_if.Q1 !== 8'h5A) begin
      errors++;
      $display("[TB] FAIL timing_post_5a: got %h expected %h", bus_if.Q1, 8'h5A);
    end
    checks++;
    if (bus_if.Q2 !== 8'h5A) begin
      errors++;
      $display("[TB] FAIL timing_post_5a_q2: got %h expected %h", bus_if.Q2, 8'h5A);
    end
    @(negedge Clock);
    bus_if.DI = 8'hA5;
    #1;
    checks++;
    if (bus_if.Q1 !== 8'h5A) begin
      errors++;
      $display("[TB] FAIL timing_pre_a5: got %h expected %h", bus_if.Q1, 8'h5A);
    end
    @(posedge Clock);
    #1;
    bus_if.REG_WE = 1'b0;
    checks++;
    if (bus_if.Q1 !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL timing_post_a5: got %h expected %h", bus_if.Q1, 8'hA5);
    end
    bus_if.N2 = 2'd2;
    #1;
    checks++;
    if (bus_if.Q2 !== 8'h33) begin
      errors++;
      $display("[TB] FAIL timing_neighbour_r2: got %h expected %h", bus_if.Q2, 8'h33);
    end
  endtask

  task automatic test_reset_vs_write;
    @(negedge Clock);
    Reset         = 1'b1;
    bus_if.REG_WE = 1'b1;
    bus_if.ND     = 2'd0;
    bus_if.DI     = 8'h77;
    @(posedge Clock);
    #1;
    Reset         = 1'b0;
    bus_if.REG_WE = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_if.N1 = 2'(i);
      #1;
      checks++;
      if (bus_if.Q1 !== 8'h00) begin
        errors++;
        $display("[TB] FAIL rst_vs_wr n1=%0d: got %h expected %h", i, bus_if.Q1, 8'h00);
      end
    end
    do_write(2'd0, 8'h77);
    bus_if.N1 = 2'd0;
    bus_if.N2 = 2'd1;
    #1;
    checks++;
    if (bus_if.Q1 !== 8'h77) begin
      errors++;
      $display("[TB] FAIL rewrite_r0: got %h expected %h", bus_if.Q1, 8'h77);
    end
    checks++;
    if (bus_if.Q2 !== 8'h00) begin
      errors++;
      $display("[TB] FAIL rewrite_r1: got %h expected %h", bus_if.Q2, 8'h00);
    end
  endtask

  // Scenario sequence.
  initial begin
    checks        = 0;
    errors        = 0;
    Reset         = 1'b0;
    bus_if.N1     = '0;
    bus_if.N2     = '0;
    bus_if.ND     = '0;
    bus_if.DI     = '0;
    bus_if.REG_WE = 1'b0;
    $display("[TB] starting reg4_8 bench");
    test_reset();
    test_basic_write();
    test_we_gating();
    test_full_sweep();
    test_write_read_timing();
    test_reset_vs_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
